aes_subbyte_arbiter: RTL
========================

# aes_subbyte_arbiter

Time-multiplexes one shared 16-lane `sub_byte` S-box array between two requesters: the cipher round datapath (full 128-bit state) and the key-expansion unit (32-bit SubWord). It sits between those two engines and the single `sub_byte` instance in the AES-128 core. Each requester has a valid/ready request channel and a one-entry registered response slot with valid/ready.

## Interface
- `ARB_MODE`, default 0: 0 = round-robin; 1 = fixed priority to key schedule, with starvation guard.
- `STARVE_LIMIT`, default 4: in `ARB_MODE`=1, the number of consecutive key-schedule grants allowed while a cipher request waits. Legal range is 1..15.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `st_req_valid`  in  1  cipher request valid.
- `st_req_data`  in  128  state to substitute.
- `st_req_ready`  out  1  cipher request accepted this cycle.
- `st_rsp_valid`  out  1  cipher result valid.
- `st_rsp_data`  out  128  substituted state.
- `st_rsp_ready`  in  1  cipher consumer takes the result.
- `ks_req_valid`  in  1  key-schedule request valid.
- `ks_req_word`  in  32  word to substitute.
- `ks_req_ready`  out  1  key-schedule request accepted.
- `ks_rsp_valid`  out  1  key-schedule result valid.
- `ks_rsp_word`  out  32  substituted word.
- `ks_rsp_ready`  in  1  key-schedule consumer takes the result.
- `sb_in`  out  128  drive to the shared `sub_byte` input.
- `sb_out`  in  128  shared `sub_byte` output, combinational from `sb_in`.

## Operation
- **Eligibility.** A requester is eligible when its req_valid=1 and its response slot is either empty or being drained this cycle (rsp_valid & rsp_ready).
- **Grant.** At most one grant per cycle. ready = grant. Ready depends combinationally on valid. Requesters must not make valid depend on ready.
- **Round-robin (`ARB_MODE`=0).**
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not granted last.
  - The `last_grant` register updates only on a grant.
- **Fixed priority (`ARB_MODE`=1).**
  - Key schedule wins when both are eligible.
  - A 4-bit `starve_cnt` increments on each key-schedule grant made while a cipher request is eligible. It clears on any cipher grant, and whenever cipher is not eligible.
  - When `starve_cnt`=`STARVE_LIMIT`, cipher wins the next tie.
- **Shared S-box drive.**
  - Cipher granted: `sb_in` = `st_req_data`.
  - Key schedule granted: `sb_in` = {96'h0, `ks_req_word`}, and the result is taken from `sb_out[31:0]`.
  - No grant: `sb_in` = 0.
- **Response slot.**
  - On a grant, the slot loads the `sb_out` result and sets rsp_valid.
  - rsp_valid clears on rsp_ready when no new load occurs in the same cycle.
  - Load and drain in the same cycle: the new data wins and rsp_valid stays 1.
- **Reset values.**
  - All rsp_valid = 0; all rsp_data/word = 0.
  - `last_grant` = cipher, so the first round-robin tie goes to key schedule.
  - `starve_cnt` = 0.
- **Reset mid-operation.** Pending responses are discarded. Requests in flight at reset are not granted in the reset cycle (all ready=0 while `rst`=1).

## Timing
- **Latency.** Request accepted in cycle t; the result appears on rsp valid/data at cycle t+1.
- **Throughput.** One substitution per cycle in aggregate. With a consumer holding rsp_ready=1, one requester alone sustains 1 per cycle.
- **Backpressure.** A full slot with rsp_ready=0 blocks further grants to that requester only. The other requester proceeds.
- **Combinational path.** The only combinational path is req → grant → `sb_in` → `sb_out` → slot D input. There is no combinational path from `sb_out` to any output.

## Structure
- Shared package `aes_pkg`:
  - requester index constants `REQ_ST`=0, `REQ_KS`=1;
  - arbitration mode constants `ARB_RR`=0, `ARB_FIXED`=1.
- Sub-module `aes_rsp_slot`: a one-entry valid/ready register, parameterized by width. It is instantiated twice (128 and 32).
- The `sub_byte` instance lives in the parent, outside this block.

## Test plan
- Cipher only, `st_req_data`=128'h0 → `st_rsp_data`=128'h6363…63 one cycle later. Input bytes 0x53 → each output byte 0xED.
- Key schedule only, `ks_req_word`=32'h09CF4F3C → `ks_rsp_word`=32'h018A84EB at t+1. `sb_in[127:32]`=0 during the grant.
- `ARB_MODE`=0, both valid continuously, both rsp_ready=1 → grants alternate KS, ST, KS, ST starting with KS after reset. Each response is correct.
- `ARB_MODE`=1, `STARVE_LIMIT`=2, both valid → grant sequence KS, KS, ST, KS, KS, ST.
- `st_rsp_ready`=0 with the slot full and both requesting → `st_req_ready` stays 0, KS is granted every cycle, and the ST result is held stable. Release → ST granted in that same cycle.
- Assert `rst` for one cycle with both slots full and requests pending → next cycle all rsp_valid=0. The first tie after reset goes to KS.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 core S-box arbitration logic.
package aes_pkg;

    // Requester index constants (also the encoding of the last_grant register)
    localparam logic REQ_ST = 1'b0;
    localparam logic REQ_KS = 1'b1;

    // Arbitration mode constants for the ARB_MODE parameter
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Width of the starvation counter
    localparam int STARVE_W = 4;

    // One-hot-free grant encoding used inside the arbiter
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ST   = 2'd1,
        GNT_KS   = 2'd2
    } grant_e;

endpackage

// File: rtl/aes_subbyte_arbiter_if.sv
// Bundle of the two requester channels plus the shared S-box drive/return.
interface aes_subbyte_arbiter_if;

    logic         st_req_valid;
    logic [127:0] st_req_data;
    logic         st_req_ready;
    logic         st_rsp_valid;
    logic [127:0] st_rsp_data;
    logic         st_rsp_ready;

    logic         ks_req_valid;
    logic [31:0]  ks_req_word;
    logic         ks_req_ready;
    logic         ks_rsp_valid;
    logic [31:0]  ks_rsp_word;
    logic         ks_rsp_ready;

    logic [127:0] sb_in;
    logic [127:0] sb_out;

    // Requester / S-box side of the bundle
    modport master (
        output st_req_valid, st_req_data, st_rsp_ready,
        output ks_req_valid, ks_req_word, ks_rsp_ready,
        output sb_out,
        input  st_req_ready, st_rsp_valid, st_rsp_data,
        input  ks_req_ready, ks_rsp_valid, ks_rsp_word,
        input  sb_in
    );

    // Arbiter side of the bundle
    modport slave (
        input  st_req_valid, st_req_data, st_rsp_ready,
        input  ks_req_valid, ks_req_word, ks_rsp_ready,
        input  sb_out,
        output st_req_ready, st_rsp_valid, st_rsp_data,
        output ks_req_ready, ks_rsp_valid, ks_rsp_word,
        output sb_in
    );

endinterface

// File: rtl/aes_rsp_slot.sv
// One-entry registered response slot with valid/ready drain.
// A load in the same cycle as a drain keeps the slot full with the new data.
module aes_rsp_slot #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Slot register: load wins over drain, reset discards contents
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (rsp_ready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign rsp_valid = valid_r;
    assign rsp_data  = data_r;

endmodule

// File: rtl/aes_subbyte_arbiter.sv
// Shares one 16-lane sub_byte array between the cipher round datapath and
// the key-expansion unit. Grants are combinational (ready = grant); results
// land in per-requester one-entry slots one cycle after acceptance.
module aes_subbyte_arbiter
    import aes_pkg::*;
#(
    parameter int ARB_MODE     = ARB_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_subbyte_arbiter_if.slave  bus
);

    logic                st_elig_s;
    logic                ks_elig_s;
    grant_e              tie_winner_s;
    grant_e              gnt_s;
    logic                st_gnt_s;
    logic                ks_gnt_s;
    logic                last_grant_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic                st_rsp_valid_s;
    logic                ks_rsp_valid_s;
    logic [127:0]        st_rsp_data_s;
    logic [31:0]         ks_rsp_word_s;

    // A requester may be served if its slot is empty or draining this cycle
    always_comb begin
        st_elig_s = bus.st_req_valid & (~st_rsp_valid_s | bus.st_rsp_ready);
        ks_elig_s = bus.ks_req_valid & (~ks_rsp_valid_s | bus.ks_rsp_ready);
    end

    // Who wins when both requesters are eligible
    always_comb begin
        tie_winner_s = GNT_KS;
        if (ARB_MODE == ARB_FIXED) begin
            if (starve_cnt_r == STARVE_W'(STARVE_LIMIT)) begin
                tie_winner_s = GNT_ST;
            end else begin
                tie_winner_s = GNT_KS;
            end
        end else begin
            if (last_grant_r == REQ_KS) begin
                tie_winner_s = GNT_ST;
            end else begin
                tie_winner_s = GNT_KS;
            end
        end
    end

    // Single grant per cycle; nothing is granted while reset is asserted
    always_comb begin
        gnt_s = GNT_NONE;
        if (rst) begin
            gnt_s = GNT_NONE;
        end else if (st_elig_s && ks_elig_s) begin
            gnt_s = tie_winner_s;
        end else if (st_elig_s) begin
            gnt_s = GNT_ST;
        end else if (ks_elig_s) begin
            gnt_s = GNT_KS;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    assign st_gnt_s = (gnt_s == GNT_ST);
    assign ks_gnt_s = (gnt_s == GNT_KS);

    // Steer the granted operand into the shared S-box, zero when idle
    always_comb begin
        bus.sb_in = 128'h0;
        case (gnt_s)
            GNT_ST:  bus.sb_in = bus.st_req_data;
            GNT_KS:  bus.sb_in = {96'h0, bus.ks_req_word};
            default: bus.sb_in = 128'h0;
        endcase
    end

    // Arbitration history: last winner and consecutive key-schedule wins
    // while the cipher waits (saturates so it can never wrap past the limit)
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= REQ_ST;
            starve_cnt_r <= '0;
        end else begin
            if (st_gnt_s) begin
                last_grant_r <= REQ_ST;
            end else if (ks_gnt_s) begin
                last_grant_r <= REQ_KS;
            end else begin
                last_grant_r <= last_grant_r;
            end

            if (st_gnt_s || !st_elig_s) begin
                starve_cnt_r <= '0;
            end else if (ks_gnt_s && (starve_cnt_r != {STARVE_W{1'b1}})) begin
                starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end
    end

    aes_rsp_slot #(.WIDTH(128)) u_st_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (st_gnt_s),
        .load_data (bus.sb_out),
        .rsp_ready (bus.st_rsp_ready),
        .rsp_valid (st_rsp_valid_s),
        .rsp_data  (st_rsp_data_s)
    );

    aes_rsp_slot #(.WIDTH(32)) u_ks_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (ks_gnt_s),
        .load_data (bus.sb_out[31:0]),
        .rsp_ready (bus.ks_rsp_ready),
        .rsp_valid (ks_rsp_valid_s),
        .rsp_data  (ks_rsp_word_s)
    );

    assign bus.st_req_ready = st_gnt_s;
    assign bus.ks_req_ready = ks_gnt_s;
    assign bus.st_rsp_valid = st_rsp_valid_s;
    assign bus.st_rsp_data  = st_rsp_data_s;
    assign bus.ks_rsp_valid = ks_rsp_valid_s;
    assign bus.ks_rsp_word  = ks_rsp_word_s;

endmodule
